rr_arbiter_mux: RTL and testbench

Round-robin arbiter with a valid/ready handshake that selects one of `INPUTS` requesters per transfer and steers its payload to a single consumer. It generates the one-hot select that drives the existing one-hot AND-OR `mux`, which it instantiates internally. It sits directly upstream of that mux wherever several lanes or units share one result path. Examples are writeback ports and a shared memory request bus.

---
 rtl/rr_arbiter_mux_pkg.sv | 16 +
 rtl/rr_arbiter_mux_mux.sv | 18 +
 rtl/rr_arbiter_mux.sv | 91 +++++++++
 tb/tb_rr_arbiter_mux.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_mux_pkg.sv
// General-purpose arbitration helpers shared by the arbiters in this codebase.
package rr_arbiter_mux_pkg;

  localparam int unsigned MaxInputs = 64;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  // One-hot of the lowest set bit; callers zero-extend narrower vectors.
  function automatic logic [MaxInputs-1:0] find_first_set(input logic [MaxInputs-1:0] vec);
    return vec & (~vec + MaxInputs'(1));
  endfunction

endpackage

// File: rtl/rr_arbiter_mux_mux.sv
// One-hot AND-OR payload mux; a zero select yields an all-zero output.
module mux #(
  parameter int unsigned INPUTS = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic [INPUTS-1:0]            sel,
  input  logic [INPUTS-1:0][WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]             data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < INPUTS; i++) begin
      data_o = data_o | (data_i[i] & {WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter with valid/ready handshake; the grant is held across stalls and
// drives the one-hot payload mux.
module rr_arbiter_mux
  import rr_arbiter_mux_pkg::*;
#(
  parameter int unsigned INPUTS = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTS-1:0]            req_i,
  input  logic [INPUTS-1:0][WIDTH-1:0] data_i,
  output logic [INPUTS-1:0]            ready_o,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             data_o,
  input  logic                         ready_i,
  output logic [INPUTS-1:0]            grant_o
);

  arb_state_e        state_q, state_d;
  logic [INPUTS-1:0] prio_q, prio_d;
  logic [INPUTS-1:0] lgrant_q, lgrant_d;
  logic [INPUTS-1:0] arb_grant;
  logic [INPUTS-1:0] prio_rot;
  logic              handshake;
  logic              stall;

  if (INPUTS == 1) begin : g_single
    assign arb_grant = req_i;
    assign prio_rot  = 1'b1;
  end else begin : g_multi
    logic [INPUTS-1:0]    mask;
    logic [INPUTS-1:0]    masked;
    logic [MaxInputs-1:0] ffs_masked;
    logic [MaxInputs-1:0] ffs_req;
    logic                 unused_ffs;

    // Bits at and above the pointer index.
    assign mask       = ~(prio_q - INPUTS'(1));
    assign masked     = req_i & mask;
    assign ffs_masked = find_first_set(MaxInputs'(masked));
    assign ffs_req    = find_first_set(MaxInputs'(req_i));
    assign arb_grant  = (|masked) ? ffs_masked[INPUTS-1:0] : ffs_req[INPUTS-1:0];
    assign prio_rot   = {grant_o[INPUTS-2:0], grant_o[INPUTS-1]};
    assign unused_ffs = ^{ffs_masked, ffs_req};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_q   <= INPUTS'(1);
      lgrant_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      lgrant_q <= lgrant_d;
    end
  end

  assign handshake = valid_o & ready_i;
  assign stall     = valid_o & ~ready_i;

  // A dropped locked request yields valid_o = 0, so the lock falls back to idle.
  always_comb begin
    state_d  = stall ? StHold : StIdle;
    lgrant_d = stall ? grant_o : lgrant_q;
    prio_d   = handshake ? prio_rot : prio_q;
  end

  always_comb begin
    grant_o = arb_grant;
    case (state_q)
      StHold:  grant_o = lgrant_q & req_i;
      default: grant_o = arb_grant;
    endcase
    valid_o = |grant_o;
    ready_o = grant_o & {INPUTS{ready_i}};
  end

  mux #(
    .INPUTS(INPUTS),
    .WIDTH (WIDTH)
  ) u_mux (
    .sel   (grant_o),
    .data_i(data_i),
    .data_o(data_o)
  );

  grant_onehot_a : assert property (@(posedge clk) $onehot0(grant_o));

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed bench for rr_arbiter_mux with a scan-based round-robin model checked every cycle.
module tb_rr_arbiter_mux;

  localparam int N = 4;
  localparam int W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_i;
  logic [N-1:0][W-1:0]   data_i;
  logic [N-1:0]          ready_o;
  logic                  valid_o;
  logic [W-1:0]          data_o;
  logic                  ready_i;
  logic [N-1:0]          grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  int m_ptr    = 0;
  int m_held   = 0;
  bit m_locked = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_mux #(
    .INPUTS(N),
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .ready_i(ready_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Index the model expects granted now, or -1 for none.
  function automatic int model_idx();
    if (m_locked) return req_i[m_held] ? m_held : -1;
    for (int s = 0; s < N; s++) begin
      int k = (m_ptr + s) % N;
      if (req_i[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr    <= 0;
      m_locked <= 1'b0;
      m_held   <= 0;
    end else if (model_idx() >= 0 && ready_i) begin
      m_ptr    <= (model_idx() + 1) % N;
      m_locked <= 1'b0;
    end else if (model_idx() >= 0) begin
      m_locked <= 1'b1;
      m_held   <= model_idx();
    end else begin
      m_locked <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int           g;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    g  = model_idx();
    eg = '0;
    ed = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ed    = data_i[g];
    end
    chk("model_grant", 32'(grant_o), 32'(eg));
    chk("model_valid", 32'(valid_o), 32'(g >= 0));
    chk("model_data", 32'(data_o), 32'(ed));
    chk("model_ready", 32'(ready_o), 32'(eg & {N{ready_i}}));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] exp_rr [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst_n   = 1'b0;
    req_i   = '0;
    ready_i = 1'b0;
    data_i  = '0;
    #2;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    ready_i = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_o), 32'h0);
    req_i     = 4'b0010;
    data_i[1] = 16'h1111;
    #1;
    chk("rst_comb_grant", 32'(grant_o), 32'b0010);
    chk("rst_comb_data", 32'(data_o), 32'h1111);
    req_i   = '0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    step();
    req_i     = 4'b0100;
    data_i[2] = 16'hBEEF;
    ready_i   = 1'b1;
    #1;
    chk("single_grant", 32'(grant_o), 32'b0100);
    chk("single_valid", 32'(valid_o), 32'h1);
    chk("single_data", 32'(data_o), 32'hBEEF);
    chk("single_ready", 32'(ready_o), 32'b0100);

    step();
    req_i = 4'b1111;
    for (int k = 0; k < N; k++) data_i[k] = 16'hA000 + 16'(k);
    #1;
    chk("ptr_at_3", 32'(grant_o), 32'b1000);

    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      chk("rr_grant", 32'(grant_o), 32'(exp_rr[i]));
    end

    step();
    req_i = 4'b1000;
    #1;
    chk("ptr_to_0", 32'(grant_o), 32'b1000);

    step();
    req_i   = 4'b0110;
    ready_i = 1'b0;
    #1;
    chk("bp_c1_grant", 32'(grant_o), 32'b0010);
    chk("bp_c1_ready", 32'(ready_o), 32'h0);
    step();
    req_i = 4'b0111;
    #1;
    chk("bp_c2_grant", 32'(grant_o), 32'b0010);
    chk("bp_c2_ready", 32'(ready_o), 32'h0);
    step();
    #1;
    chk("bp_c3_grant", 32'(grant_o), 32'b0010);
    step();
    ready_i = 1'b1;
    #1;
    chk("bp_xfer_grant", 32'(grant_o), 32'b0010);
    chk("bp_xfer_ready", 32'(ready_o), 32'b0010);
    chk("bp_xfer_data", 32'(data_o), 32'hA001);
    step();
    #1;
    chk("bp_next", 32'(grant_o), 32'b0100);

    step();
    req_i = 4'b1001;
    #1;
    chk("wrap_3", 32'(grant_o), 32'b1000);
    step();
    #1;
    chk("wrap_0", 32'(grant_o), 32'b0001);

    step();
    req_i   = 4'b0100;
    ready_i = 1'b0;
    #1;
    chk("hold_enter", 32'(grant_o), 32'b0100);
    step();
    #1;
    chk("hold_keep", 32'(grant_o), 32'b0100);
    #1;
    rst_n = 1'b0;
    req_i = 4'b1101;
    #1;
    chk("rst_lock_clr", 32'(grant_o), 32'b0001);
    req_i   = 4'b1100;
    ready_i = 1'b1;
    #1;
    chk("rst_grant2", 32'(grant_o), 32'b0100);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant2", 32'(grant_o), 32'b0100);

    step();
    req_i = 4'b0001;
    #1;
    chk("viol_setup", 32'(grant_o), 32'b0001);
    step();
    req_i   = 4'b1010;
    ready_i = 1'b0;
    #1;
    chk("viol_hold", 32'(grant_o), 32'b0010);
    step();
    req_i = 4'b1000;
    #1;
    chk("viol_grant", 32'(grant_o), 32'h0);
    chk("viol_valid", 32'(valid_o), 32'h0);
    chk("viol_data", 32'(data_o), 32'h0);
    step();
    #1;
    chk("viol_next", 32'(grant_o), 32'b1000);
    chk("viol_next_data", 32'(data_o), 32'hA003);

    step();
    req_i = '0;
    #1;
    chk("idle_grant", 32'(grant_o), 32'h0);
    chk("idle_valid", 32'(valid_o), 32'h0);
    chk("idle_data", 32'(data_o), 32'h0);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
